// File: rtl/mem_writeback_pkg.sv
`default_nettype none
// ============================================================================
// mem_writeback_pkg : shared encodings for the memory / write-back stage
// Rev 1.0
// ============================================================================
package mem_writeback_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_writeback_load_store_align.sv
`default_nettype none
// ============================================================================
// load_store_align : byte-lane steering for stores and load data formatting
// Rev 1.0
// ============================================================================
module load_store_align
  import mem_writeback_pkg::*;
(
  input  logic [2:0]  fun3,
  input  logic [1:0]  addr,
  input  logic [31:0] store_data,
  input  logic [31:0] dmem_rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    case (fun3)
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LBU:     load_data = {24'b0, byte_sel};
      LHU:     load_data = {16'b0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

  // Store fun3 arrives already folded onto SB/SH/SW by the caller.
  always_comb begin
    case (fun3)
      SB: begin
        mask  = 4'b0001 << addr;
        wdata = {4{store_data[7:0]}};
      end
      SH: begin
        mask  = 4'b0011 << addr;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        mask  = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    case (fun3)
      LB, LBU: misaligned = 1'b0;
      LH, LHU: misaligned = addr[0];
      default: misaligned = |addr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_writeback.sv
`default_nettype none
// ============================================================================
// mem_writeback : RV32I memory-access and register write-back stage
// Rev 1.0
// ============================================================================
module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        load,
  input  logic        store,
  input  logic        reg_write_in,
  input  logic [1:0]  mem_to_reg,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [31:0] pc_address,
  input  logic [31:0] instruction,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mask,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        reg_write_out,
  output logic [31:0] rd_wb_data,
  output logic [31:0] instruction_rd_add,
  output logic        bus_err,
  output logic        misalign_err
);

  localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       fun3_q, fun3_d;
  logic [4:0]       rd_q, rd_d;
  logic             rw_q, rw_d;
  logic             dmem_req_q, dmem_req_d;
  logic             dmem_we_q, dmem_we_d;
  logic [31:0]      dmem_addr_q, dmem_addr_d;
  logic [31:0]      dmem_wdata_q, dmem_wdata_d;
  logic [3:0]       dmem_mask_q, dmem_mask_d;
  logic             reg_write_out_q, reg_write_out_d;
  logic [31:0]      rd_wb_data_q, rd_wb_data_d;
  logic [4:0]       rd_add_q, rd_add_d;
  logic             bus_err_q, bus_err_d;
  logic             misalign_err_q, misalign_err_d;

  logic [4:0]  rd_in;
  logic [2:0]  fun3_in, fun3_eff, al_fun3;
  logic [1:0]  al_addr;
  logic [3:0]  al_mask;
  logic [31:0] al_wdata, al_load, wb_alu;
  logic        al_mis;
  logic        unused_instr;

  assign rd_in        = instruction[11:7];
  assign fun3_in      = instruction[14:12];
  assign unused_instr = ^{instruction[31:15], instruction[6:0]};

  // Undefined store widths behave as SW, so fold them before alignment.
  assign fun3_eff = (store && fun3_in != SB && fun3_in != SH) ? SW : fun3_in;

  // While a load is outstanding the aligner formats from the captured access.
  assign al_fun3 = (state_q == ACCESS) ? fun3_q : fun3_eff;
  assign al_addr = (state_q == ACCESS) ? dmem_addr_q[1:0] : alu_result[1:0];

  load_store_align u_align (
    .fun3       (al_fun3),
    .addr       (al_addr),
    .store_data (store_data),
    .dmem_rdata (dmem_rdata),
    .mask       (al_mask),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_mis)
  );

  always_comb begin
    case (mem_to_reg)
      WB_MEM:  wb_alu = al_load;
      WB_PC4:  wb_alu = pc_address + 32'd4;
      default: wb_alu = alu_result;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    fun3_d          = fun3_q;
    rd_d            = rd_q;
    rw_d            = rw_q;
    dmem_req_d      = dmem_req_q;
    dmem_we_d       = dmem_we_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_wdata_d    = dmem_wdata_q;
    dmem_mask_d     = dmem_mask_q;
    reg_write_out_d = reg_write_out_q;
    rd_wb_data_d    = rd_wb_data_q;
    rd_add_d        = rd_add_q;
    bus_err_d       = 1'b0;
    misalign_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!valid_in) begin
          reg_write_out_d = 1'b0;
        end else if (load || store) begin
          reg_write_out_d = 1'b0;
          if (al_mis) begin
            misalign_err_d = 1'b1;
          end else begin
            state_d      = ACCESS;
            cnt_d        = '0;
            fun3_d       = fun3_eff;
            rd_d         = rd_in;
            rw_d         = reg_write_in;
            dmem_req_d   = 1'b1;
            dmem_we_d    = store;
            dmem_addr_d  = alu_result;
            dmem_wdata_d = store ? al_wdata : 32'b0;
            dmem_mask_d  = store ? al_mask : 4'b0;
          end
        end else begin
          rd_wb_data_d    = wb_alu;
          rd_add_d        = rd_in;
          reg_write_out_d = reg_write_in && (rd_in != 5'd0);
        end
      end

      ACCESS: begin
        if (dmem_ack) begin
          state_d    = IDLE;
          cnt_d      = '0;
          dmem_req_d = 1'b0;
          if (!dmem_we_q) begin
            rd_wb_data_d    = al_load;
            rd_add_d        = rd_q;
            reg_write_out_d = rw_q && (rd_q != 5'd0);
          end else begin
            reg_write_out_d = 1'b0;
          end
        end else if (TMO_EN && cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          dmem_req_d = 1'b0;
          bus_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      fun3_q          <= '0;
      rd_q            <= '0;
      rw_q            <= 1'b0;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= '0;
      dmem_wdata_q    <= '0;
      dmem_mask_q     <= '0;
      reg_write_out_q <= 1'b0;
      rd_wb_data_q    <= '0;
      rd_add_q        <= '0;
      bus_err_q       <= 1'b0;
      misalign_err_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      fun3_q          <= fun3_d;
      rd_q            <= rd_d;
      rw_q            <= rw_d;
      dmem_req_q      <= dmem_req_d;
      dmem_we_q       <= dmem_we_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_wdata_q    <= dmem_wdata_d;
      dmem_mask_q     <= dmem_mask_d;
      reg_write_out_q <= reg_write_out_d;
      rd_wb_data_q    <= rd_wb_data_d;
      rd_add_q        <= rd_add_d;
      bus_err_q       <= bus_err_d;
      misalign_err_q  <= misalign_err_d;
    end
  end

  assign stall              = (state_q == ACCESS);
  assign dmem_req           = dmem_req_q;
  assign dmem_we            = dmem_we_q;
  assign dmem_addr          = dmem_addr_q;
  assign dmem_wdata         = dmem_wdata_q;
  assign dmem_mask          = dmem_mask_q;
  assign reg_write_out      = reg_write_out_q;
  assign rd_wb_data         = rd_wb_data_q;
  assign instruction_rd_add = {20'b0, rd_add_q, 7'b0};
  assign bus_err            = bus_err_q;
  assign misalign_err       = misalign_err_q;

endmodule
`default_nettype wire
